io_pad_arbiter: RTL



---
 rtl/io_arb_pkg.sv | 19 +
 rtl/io_arb_rr_pick.sv | 33 +++
 rtl/io_pad_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/io_arb_pkg.sv
// io_arb_pkg: shared state type, counter sizing helper and pad tristate
// constant for the IO pad arbiter.
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam logic OEB_TRISTATE = 1'b1;

  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/io_arb_rr_pick.sv
// io_arb_rr_pick: combinational round-robin picker. The search starts one
// past ptr and wraps, so the requester at ptr has the lowest priority.
module io_arb_rr_pick
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] winner
);

  logic [PTR_W-1:0] idx;
  logic             found;

  // Walk the requesters in priority order starting after ptr; first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    valid = found;
  end

endmodule

// File: rtl/io_pad_arbiter.sv
// io_pad_arbiter: grants the whole user IO bank to one requester at a time,
// round-robin, with a tristate turnaround window between owners.
// Optional feature macro: IO_ARB_TENURE_EN (tenure limit / preemption).
module io_pad_arbiter
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IO_WIDTH    = 24,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_HOLD    = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*IO_WIDTH-1:0]  req_out,
  input  logic [NUM_REQ*IO_WIDTH-1:0]  req_oeb,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  input  logic [IO_WIDTH-1:0]          io_in,
  output logic [IO_WIDTH-1:0]          io_rd,
  output logic [IO_WIDTH-1:0]          io_out,
  output logic [IO_WIDTH-1:0]          io_oeb
);

  localparam int                  PTR_W      = $clog2(NUM_REQ);
  localparam int                  DRAIN_W    = cnt_width(TURN_CYCLES);
  localparam logic [IO_WIDTH-1:0] PADS_OFF   = {IO_WIDTH{OEB_TRISTATE}};
  localparam logic [PTR_W-1:0]    PTR_RESET  = PTR_W'(NUM_REQ - 1);
  localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(TURN_CYCLES - 1);

  arb_state_t           state, state_n;
  logic [NUM_REQ-1:0]   grant_n;
  logic [PTR_W-1:0]     ptr, ptr_n;
  logic [DRAIN_W-1:0]   drain_cnt, drain_cnt_n;
  logic [IO_WIDTH-1:0]  io_out_n, io_oeb_n;

  logic                 pick_valid;
  logic [NUM_REQ-1:0]   pick_winner;
  logic [PTR_W-1:0]     pick_idx;
  logic                 owner_req;
  logic                 others_req;
  logic                 preempt;

  logic [IO_WIDTH-1:0]  slice_out [NUM_REQ];
  logic [IO_WIDTH-1:0]  slice_oeb [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice_out[g] = req_out[g*IO_WIDTH +: IO_WIDTH];
    assign slice_oeb[g] = req_oeb[g*IO_WIDTH +: IO_WIDTH];
  end

  io_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Convert the one-hot winner into an index for the round-robin pointer.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_winner[i]) pick_idx = PTR_W'(i);
    end
  end

  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);

`ifdef IO_ARB_TENURE_EN
  localparam int                 HOLD_W   = cnt_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] tenure;

  // Count owned cycles, cleared on each entry into OWN, saturating at MAX_HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tenure <= '0;
    end else if (state_n == OWN && state != OWN) begin
      tenure <= '0;
    end else if (state == OWN && tenure != HOLD_MAX) begin
      tenure <= tenure + 1'b1;
    end
  end

  assign preempt = (tenure == HOLD_MAX) && others_req;
`else
  assign preempt = 1'b0;
`endif

  // Next-state logic: arbitration, release/preemption, turnaround and pad data.
  always_comb begin
    state_n     = state;
    grant_n     = grant;
    ptr_n       = ptr;
    drain_cnt_n = drain_cnt;
    io_out_n    = io_out;
    io_oeb_n    = io_oeb;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = OWN;
          grant_n = pick_winner;
          ptr_n   = pick_idx;
        end
      end
      OWN: begin
        if (!owner_req || preempt) begin
          state_n     = DRAIN;
          grant_n     = '0;
          drain_cnt_n = '0;
          io_out_n    = '0;
          io_oeb_n    = PADS_OFF;
        end else begin
          io_out_n = slice_out[ptr];
          io_oeb_n = slice_oeb[ptr];
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          drain_cnt_n = '0;
          if (pick_valid) begin
            state_n = OWN;
            grant_n = pick_winner;
            ptr_n   = pick_idx;
          end else begin
            state_n = IDLE;
          end
        end else begin
          drain_cnt_n = drain_cnt + 1'b1;
        end
      end
      default: begin
        state_n  = IDLE;
        grant_n  = '0;
        io_out_n = '0;
        io_oeb_n = PADS_OFF;
      end
    endcase
  end

  // State, grant, pointer, drain counter and pad registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= PTR_RESET;
      drain_cnt <= '0;
      io_out    <= '0;
      io_oeb    <= PADS_OFF;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      ptr       <= ptr_n;
      drain_cnt <= drain_cnt_n;
      io_out    <= io_out_n;
      io_oeb    <= io_oeb_n;
    end
  end

  assign busy  = (state != IDLE);
  assign io_rd = io_in;

endmodule
